// File: rtl/fu_gemm_issue_queue.sv
// GEMM front end: DEPTH-entry instruction FIFO with resident-weight tracking.
// Optional same-cycle empty-queue bypass is compiled in with FU_GEMM_BYPASS_EN.
module fu_gemm_issue_queue #(
  parameter int MAT_W = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               flush,
  input  logic               gemm_enable,
  input  logic               new_weight_in,
  input  logic [MAT_W-1:0]   rs1_in,
  input  logic [MAT_W-1:0]   rs2_in,
  input  logic [MAT_W-1:0]   rs3_in,
  input  logic [MAT_W-1:0]   rd_in,
  output logic               gemm_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*MAT_W-1:0] gemm_out,
  output logic               new_weight_out,
  output logic [CNT_W-1:0]   occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = 4 * MAT_W + 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready
  // (gemm_enable/gemm_ready upstream, out_valid/out_ready downstream), and
  // flush at that edge cancels both transfers.

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [MAT_W-1:0] last_w;
  logic             last_w_valid;

  logic [ENT_W-1:0] in_ent, head_ent;
  logic [MAT_W-1:0] head_rs2;
  logic             head_hint;
  logic             full, bypass, enq, deq, fifo_deq;

  assign in_ent = {new_weight_in, rd_in, rs3_in, rs2_in, rs1_in};

`ifdef FU_GEMM_BYPASS_EN
  assign bypass   = (count == '0) && gemm_enable && out_ready && !flush;
  assign head_ent = bypass ? in_ent : mem[rd_ptr];
`else
  assign bypass   = 1'b0;
  assign head_ent = mem[rd_ptr];
`endif

  assign head_rs2  = head_ent[2*MAT_W-1:MAT_W];
  assign head_hint = head_ent[ENT_W-1];

  assign full       = (count == CNT_W'(DEPTH));
  assign gemm_ready = !full && !flush;
  assign out_valid  = (count != '0) || bypass;
  assign enq        = gemm_enable && gemm_ready && !bypass;
  assign deq        = out_valid && out_ready && !flush;
  // A bypassed instruction never touches storage, so only the FIFO path moves rd_ptr.
  assign fifo_deq   = deq && !bypass;

  assign gemm_out       = out_valid ? head_ent[4*MAT_W-1:0] : '0;
  assign new_weight_out = out_valid && (head_hint || !last_w_valid || (head_rs2 != last_w));
  assign occupancy      = count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      last_w       <= '0;
      last_w_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      last_w_valid <= 1'b0;
    end else begin
      if (enq)      wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, fifo_deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // Weight residency follows what the sequencer actually consumed.
      if (deq) begin
        last_w       <= head_rs2;
        last_w_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (enq) mem[wr_ptr] <= in_ent;
  end

endmodule

// File: tb/tb_fu_gemm_issue_queue.sv
// Directed bench for fu_gemm_issue_queue (DEPTH=4, MAT_W=4); honours FU_GEMM_BYPASS_EN.
module tb_fu_gemm_issue_queue;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        flush = 1'b0;
  logic        gemm_enable = 1'b0;
  logic        new_weight_in = 1'b0;
  logic [3:0]  rs1_in = '0, rs2_in = '0, rs3_in = '0, rd_in = '0;
  logic        gemm_ready, out_valid, new_weight_out;
  logic        out_ready = 1'b0;
  logic [15:0] gemm_out;
  logic [2:0]  occupancy;

  int checks = 0;
  int failures = 0;

  fu_gemm_issue_queue #(.MAT_W(4), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .gemm_enable(gemm_enable),
    .new_weight_in(new_weight_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
    .rs3_in(rs3_in), .rd_in(rd_in), .gemm_ready(gemm_ready),
    .out_valid(out_valid), .out_ready(out_ready), .gemm_out(gemm_out),
    .new_weight_out(new_weight_out), .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic nw, input logic [15:0] f);
    new_weight_in = nw;
    {rd_in, rs3_in, rs2_in, rs1_in} = f;
  endtask

  task automatic enq(input logic nw, input logic [15:0] f);
    set_in(nw, f);
    gemm_enable = 1'b1;
    step();
    gemm_enable = 1'b0;
  endtask

  initial begin
    // Reset, then an asynchronous mid-cycle reset pulse over a non-empty queue
    #12 RST = 1'b0;
    step();
    enq(1'b0, 16'h1234);
    chk("pre_rst_occ", occupancy, 1);
    #2 RST = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", gemm_ready, 1);
    chk("rst_occ", occupancy, 0);
    chk("rst_nw", new_weight_out, 0);
    chk("rst_out", gemm_out, 0);
    RST = 1'b0;
    step();

    // Fill with out_ready low, overflow attempt, then drain in order
    enq(1'b0, 16'h1234); chk("fill_occ1", occupancy, 1);
    enq(1'b0, 16'h5678); chk("fill_occ2", occupancy, 2);
    enq(1'b0, 16'h9ABC); chk("fill_occ3", occupancy, 3);
    enq(1'b0, 16'hDEF0); chk("fill_occ4", occupancy, 4);
    chk("full_ready", gemm_ready, 0);
    chk("full_head", gemm_out, 16'h1234);
    enq(1'b0, 16'h1111);
    chk("drop_occ", occupancy, 4);
    chk("drop_head", gemm_out, 16'h1234);
    out_ready = 1'b1;
    chk("drain_out0", gemm_out, 16'h1234); chk("drain_occ0", occupancy, 4); chk("drain_nw0", new_weight_out, 1);
    step();
    chk("drain_out1", gemm_out, 16'h5678); chk("drain_occ1", occupancy, 3); chk("drain_nw1", new_weight_out, 1);
    step();
    chk("drain_out2", gemm_out, 16'h9ABC); chk("drain_occ2", occupancy, 2);
    step();
    chk("drain_out3", gemm_out, 16'hDEF0); chk("drain_occ3", occupancy, 1);
    step();
    chk("drain_empty_valid", out_valid, 0);
    chk("drain_empty_occ", occupancy, 0);
    chk("drain_empty_out", gemm_out, 0);
    out_ready = 1'b0;

    // Weight reuse: rs2 = 3,3,7 (no hint), then 7 with hint
    enq(1'b0, 16'h1030);
    enq(1'b0, 16'h2030);
    enq(1'b0, 16'h3070);
    out_ready = 1'b1;
    chk("wr_out0", gemm_out, 16'h1030); chk("wr_nw0", new_weight_out, 1);
    step();
    chk("wr_out1", gemm_out, 16'h2030); chk("wr_nw1", new_weight_out, 0);
    step();
    chk("wr_out2", gemm_out, 16'h3070); chk("wr_nw2", new_weight_out, 1);
    step();
    out_ready = 1'b0;
    enq(1'b1, 16'h4070);
    chk("wr_out3", gemm_out, 16'h4070); chk("wr_nw3_hint", new_weight_out, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("wr_empty", out_valid, 0);

    // Simultaneous enqueue/dequeue at occupancy 2, pointers wrap
    enq(1'b0, 16'h1111);
    enq(1'b0, 16'h2222);
    out_ready = 1'b1;
    gemm_enable = 1'b1;
    for (int j = 0; j < 8; j++) begin
      set_in(1'b0, 16'h1111 * (j + 3));
      #1;
      chk($sformatf("sim_head%0d", j), gemm_out, 16'h1111 * (j + 1));
      chk($sformatf("sim_occ%0d", j), occupancy, 2);
      chk($sformatf("sim_ready%0d", j), gemm_ready, 1);
      step();
    end
    gemm_enable = 1'b0;
    chk("sim_tail0", gemm_out, 16'h9999); chk("sim_tail_occ", occupancy, 2);
    step();
    chk("sim_tail1", gemm_out, 16'hAAAA);
    step();
    chk("sim_done", occupancy, 0);
    out_ready = 1'b0;

    // Flush with occupancy 3 and concurrent enqueue/dequeue; last_w was 0xA
    enq(1'b0, 16'h1111);
    enq(1'b0, 16'h2222);
    enq(1'b0, 16'h3333);
    chk("fl_pre_occ", occupancy, 3);
    set_in(1'b0, 16'h4444);
    gemm_enable = 1'b1;
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    chk("fl_ready", gemm_ready, 0);
    step();
    flush = 1'b0;
    gemm_enable = 1'b0;
    out_ready = 1'b0;
    chk("fl_occ", occupancy, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_out", gemm_out, 0);
    enq(1'b0, 16'h50A0);
    chk("fl_post_out", gemm_out, 16'h50A0);
    chk("fl_post_nw", new_weight_out, 1);
    chk("fl_post_occ", occupancy, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    enq(1'b0, 16'h60A0);
    chk("fl_resident_nw", new_weight_out, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("fl_drained", occupancy, 0);

    // Empty queue, enqueue with out_ready high: bypass or one-cycle latency
    set_in(1'b0, 16'h6758);
    gemm_enable = 1'b1;
    out_ready = 1'b1;
    #1;
`ifdef FU_GEMM_BYPASS_EN
    chk("byp_valid", out_valid, 1);
    chk("byp_out", gemm_out, 16'h6758);
    chk("byp_nw", new_weight_out, 1);
    chk("byp_ready", gemm_ready, 1);
    step();
    gemm_enable = 1'b0;
    chk("byp_occ", occupancy, 0);
    chk("byp_after_valid", out_valid, 0);
`else
    chk("lat_valid0", out_valid, 0);
    chk("lat_out0", gemm_out, 0);
    step();
    gemm_enable = 1'b0;
    chk("lat_valid1", out_valid, 1);
    chk("lat_out1", gemm_out, 16'h6758);
    chk("lat_nw1", new_weight_out, 1);
    chk("lat_occ1", occupancy, 1);
    step();
    chk("lat_occ2", occupancy, 0);
`endif
    out_ready = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
